fp_mult_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshakes on both sides.
- Successor to the team's combinational single-precision multiplier.
- Generic exponent and mantissa widths, fixed 3-stage pipeline with backpressure, round-to-nearest-even, special-value handling and exception flags.
- Sits between operand-fetch and result-writeback in the accelerator datapath.

---
 rtl/fp_pkg.sv | 36 +++
 rtl/fp_mult_if.sv | 31 +++
 rtl/fp_round_ne.sv | 20 ++
 rtl/fp_mult_pipe.sv | 198 +++++++++++++++++++
 tb/tb_fp_mult_pipe.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants, operand classes and helpers.
// Width-generic: every helper takes the exponent/mantissa widths.
package fp_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_cls_e;

  // Resolved special case, already in priority order.
  typedef enum logic [1:0] {
    SP_NONE,
    SP_INV,
    SP_INF,
    SP_ZERO
  } fp_sp_e;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int fp_exp_ones(input int ew);
    return (1 << ew) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all-ones, fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int ew, input int mw);
    logic [63:0] v;
    v = ((64'd1 << ew) - 64'd1) << mw;
    v = v | (64'd1 << (mw - 1));
    return v;
  endfunction

endpackage

// File: rtl/fp_mult_if.sv
// Operand/result handshake bundle for fp_mult_pipe.
// master: operand producer + result consumer; slave: the multiplier.
interface fp_mult_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();
  localparam int DW = 1 + EXP_W + MAN_W;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_1;
  logic [DW-1:0] data_2;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_prod;
  logic          flag_ovf;
  logic          flag_unf;
  logic          flag_inv;

  modport master (
    output in_valid, data_1, data_2, out_ready,
    input  in_ready, out_valid, data_prod,
    input  flag_ovf, flag_unf, flag_inv
  );

  modport slave (
    input  in_valid, data_1, data_2, out_ready,
    output in_ready, out_valid, data_prod,
    output flag_ovf, flag_unf, flag_inv
  );
endinterface

// File: rtl/fp_round_ne.sv
// Round-to-nearest-even on a normalised fraction.
// In: fraction, guard/round/sticky. Out: rounded fraction, carry-out.
module fp_round_ne #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W-1:0] i_man,
  input  logic             i_g,
  input  logic             i_r,
  input  logic             i_s,
  output logic [MAN_W-1:0] o_man,
  output logic             o_carry
);
  logic w_up;

  // Exact tie (g=1, r=s=0) rounds up only when the LSB is odd.
  assign w_up = i_g & (i_r | i_s | i_man[0]);

  // On carry-out the fraction wraps to zero, i.e. 1.0 at exponent+1.
  assign {o_carry, o_man} = {1'b0, i_man} + {{MAN_W{1'b0}}, w_up};
endmodule

// File: rtl/fp_mult_pipe.sv
// 3-stage pipelined FP multiplier (unpack / multiply / round+pack).
// Ports: clk, rst_n (async low), bus (fp_mult_if.slave handshake).
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic        clk,
  input logic        rst_n,
  fp_mult_if.slave   bus
);
  localparam int DW  = 1 + EXP_W + MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;

  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic signed [EW2-1:0] BIAS_S =
    EW2'(fp_bias(EXP_W));
  localparam logic signed [EW2-1:0] EMAX =
    EW2'(fp_exp_ones(EXP_W));
  localparam logic [63:0] QNAN64 = fp_qnan(EXP_W, MAN_W);
  localparam logic [DW-1:0] QNAN = QNAN64[DW-1:0];

  function automatic fp_cls_e classify(
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] f
  );
    fp_cls_e c;
    c = CLS_NORM;
    unique case (1'b1)
      (e == '0):                  c = CLS_ZERO;
      (e == EONES && f == '0):    c = CLS_INF;
      (e == EONES && f != '0):    c = CLS_NAN;
      default:                    c = CLS_NORM;
    endcase
    return c;
  endfunction

  logic w_en;
  assign w_en         = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = w_en;

  // ---- S1 unpack
  logic [EXP_W-1:0]      w_ea, w_eb;
  logic [MAN_W-1:0]      w_fa, w_fb;
  logic signed [EW2-1:0] w_esum;

  assign w_ea   = bus.data_1[DW-2 -: EXP_W];
  assign w_eb   = bus.data_2[DW-2 -: EXP_W];
  assign w_fa   = bus.data_1[MAN_W-1:0];
  assign w_fb   = bus.data_2[MAN_W-1:0];
  assign w_esum = $signed({2'b00, w_ea})
                + $signed({2'b00, w_eb}) - BIAS_S;

  logic                  r1_v, r1_sgn;
  logic signed [EW2-1:0] r1_esum;
  logic [MAN_W:0]        r1_ma, r1_mb;
  fp_cls_e               r1_ca, r1_cb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v    <= 1'b0;
      r1_sgn  <= 1'b0;
      r1_esum <= '0;
      r1_ma   <= '0;
      r1_mb   <= '0;
      r1_ca   <= CLS_ZERO;
      r1_cb   <= CLS_ZERO;
    end else if (w_en) begin
      r1_v    <= bus.in_valid;
      r1_sgn  <= bus.data_1[DW-1] ^ bus.data_2[DW-1];
      r1_esum <= w_esum;
      r1_ma   <= {1'b1, w_fa};
      r1_mb   <= {1'b1, w_fb};
      r1_ca   <= classify(w_ea, w_fa);
      r1_cb   <= classify(w_eb, w_fb);
    end
  end

  // ---- S2 multiply, specials resolved to one code
  logic [PW-1:0] w_prod;
  fp_sp_e        w_sp;
  logic          w_nan, w_inf, w_zero;

  assign w_prod = PW'(r1_ma) * PW'(r1_mb);
  assign w_nan  = (r1_ca == CLS_NAN) | (r1_cb == CLS_NAN);
  assign w_inf  = (r1_ca == CLS_INF) | (r1_cb == CLS_INF);
  assign w_zero = (r1_ca == CLS_ZERO) | (r1_cb == CLS_ZERO);

  always_comb begin
    w_sp = SP_NONE;
    if (w_nan || (w_inf && w_zero)) w_sp = SP_INV;
    else if (w_inf)                 w_sp = SP_INF;
    else if (w_zero)                w_sp = SP_ZERO;
  end

  logic                  r2_v, r2_sgn;
  logic signed [EW2-1:0] r2_esum;
  logic [PW-1:0]         r2_prod;
  fp_sp_e                r2_sp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v    <= 1'b0;
      r2_sgn  <= 1'b0;
      r2_esum <= '0;
      r2_prod <= '0;
      r2_sp   <= SP_NONE;
    end else if (w_en) begin
      r2_v    <= r1_v;
      r2_sgn  <= r1_sgn;
      r2_esum <= r1_esum;
      r2_prod <= w_prod;
      r2_sp   <= w_sp;
    end
  end

  // ---- S3 normalise, round, pack
  logic                  w_msb, w_carry;
  logic [PW-1:0]         w_norm;
  logic [MAN_W-1:0]      w_man;
  logic signed [EW2-1:0] w_eadj;
  logic                  w_ovf_n, w_unf_n;

  // Product is in [1,4): align so the leading 1 sits at bit PW-1.
  assign w_msb  = r2_prod[PW-1];
  assign w_norm = w_msb ? r2_prod : {r2_prod[PW-2:0], 1'b0};

  fp_round_ne #(.MAN_W(MAN_W)) u_rnd (
    .i_man   (w_norm[PW-2 -: MAN_W]),
    .i_g     (w_norm[MAN_W]),
    .i_r     (w_norm[MAN_W-1]),
    .i_s     (|w_norm[MAN_W-2:0]),
    .o_man   (w_man),
    .o_carry (w_carry)
  );

  assign w_eadj  = r2_esum
                 + $signed({{(EW2-1){1'b0}}, w_msb})
                 + $signed({{(EW2-1){1'b0}}, w_carry});
  assign w_ovf_n = !w_eadj[EW2-1] && (w_eadj >= EMAX);
  assign w_unf_n = w_eadj[EW2-1] || (w_eadj == '0);

  logic [DW-1:0] w_res;
  logic          w_ovf, w_unf, w_inv;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inv = 1'b0;
    unique case (r2_sp)
      SP_INV: begin
        w_res = QNAN;
        w_inv = 1'b1;
      end
      SP_INF:  w_res = {r2_sgn, EONES, {MAN_W{1'b0}}};
      SP_ZERO: w_res = {r2_sgn, {(DW-1){1'b0}}};
      default: begin
        if (w_ovf_n) begin
          w_res = {r2_sgn, EONES, {MAN_W{1'b0}}};
          w_ovf = 1'b1;
        end else if (w_unf_n) begin
          w_res = {r2_sgn, {(DW-1){1'b0}}};
          w_unf = 1'b1;
        end else begin
          w_res = {r2_sgn, w_eadj[EXP_W-1:0], w_man};
        end
      end
    endcase
  end

  logic          r3_v, r3_ovf, r3_unf, r3_inv;
  logic [DW-1:0] r3_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_v    <= 1'b0;
      r3_data <= '0;
      r3_ovf  <= 1'b0;
      r3_unf  <= 1'b0;
      r3_inv  <= 1'b0;
    end else if (w_en) begin
      r3_v    <= r2_v;
      r3_data <= w_res;
      r3_ovf  <= r2_v & w_ovf;
      r3_unf  <= r2_v & w_unf;
      r3_inv  <= r2_v & w_inv;
    end
  end

  assign bus.out_valid = r3_v;
  assign bus.data_prod = r3_data;
  assign bus.flag_ovf  = r3_ovf;
  assign bus.flag_unf  = r3_unf;
  assign bus.flag_inv  = r3_inv;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe (single and half precision).
// Directed vectors; expected results are hand-computed constants.
module tb_fp_mult_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mult_if #(.EXP_W(8), .MAN_W(23)) m32 ();
  fp_mult_if #(.EXP_W(5), .MAN_W(10)) m16 ();

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(m32.slave)
  );
  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(m16.slave)
  );

  typedef struct {
    logic [31:0] d;
    logic [2:0]  f;   // {ovf, unf, inv}
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic send32(input logic [31:0] a, b, d,
                        input logic [2:0] f, input bit lat);
    exp_t e;
    int g = 0;
    m32.in_valid = 1'b1;
    m32.data_1 = a;
    m32.data_2 = b;
    #1;
    while (!m32.in_ready && g < 100) begin
      @(negedge clk); #1; g++;
    end
    if (g >= 100) chk("send32_timeout", 64'(g), 64'd0);
    e.d = d; e.f = f; e.acc = cyc; e.lat = lat;
    q32.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send16(input logic [15:0] a, b, d,
                        input logic [2:0] f);
    exp_t e;
    m16.in_valid = 1'b1;
    m16.data_1 = a;
    m16.data_2 = b;
    #1;
    e.d = {16'h0, d}; e.f = f; e.acc = cyc; e.lat = 1'b1;
    q16.push_back(e);
    @(posedge clk);
    @(negedge clk);
    m16.in_valid = 1'b0;
  endtask

  // Monitors: sample mid-low-phase, after negedge-driven inputs settle.
  always begin
    exp_t e;
    @(negedge clk); #2;
    if (m32.out_valid && m32.out_ready) begin
      if (q32.size() == 0) begin
        chk("res32_unexpected", {32'h0, m32.data_prod}, 64'hDEAD);
      end else begin
        e = q32.pop_front();
        chk("res32", {29'h0, m32.flag_ovf, m32.flag_unf,
                      m32.flag_inv, m32.data_prod}, {29'h0, e.f, e.d});
        if (e.lat) chk("lat32", 64'(cyc - e.acc), 64'd3);
      end
    end
    if (m16.out_valid && m16.out_ready) begin
      if (q16.size() == 0) begin
        chk("res16_unexpected", {48'h0, m16.data_prod}, 64'hDEAD);
      end else begin
        e = q16.pop_front();
        chk("res16", {29'h0, m16.flag_ovf, m16.flag_unf,
                      m16.flag_inv, 16'h0, m16.data_prod},
            {29'h0, e.f, e.d});
        chk("lat16", 64'(cyc - e.acc), 64'd3);
      end
    end
  end

  logic [31:0] held;

  initial begin
    m32.in_valid = 0; m32.data_1 = 0; m32.data_2 = 0; m32.out_ready = 1;
    m16.in_valid = 0; m16.data_1 = 0; m16.data_2 = 0; m16.out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_state", {28'h0, m32.out_valid, m32.flag_ovf, m32.flag_unf,
                      m32.flag_inv, m32.data_prod}, 64'd0);
    chk("rst_in_ready", 64'(m32.in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal, rounding, specials, range limits
    send32(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 1);
    m32.in_valid = 0;
    repeat (4) @(negedge clk);
    send32(32'hC0400000, 32'h40000000, 32'hC0C00000, 3'b000, 1);
    send32(32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 1);
    send32(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000, 1);
    send32(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 1);
    send32(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1);
    send32(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001, 1);
    send32(32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 1);
    send32(32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, 1);
    send32(32'h00800000, 32'h00800000, 32'h00000000, 3'b010, 1);
    send32(32'h00000001, 32'h3F800000, 32'h00000000, 3'b000, 1);
    m32.in_valid = 0;
    repeat (6) @(negedge clk);

    // Backpressure: 5 pairs, 4-cycle stall after first out_valid
    fork
      begin
        send32(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 0);
        send32(32'h3F800000, 32'h40000000, 32'h40000000, 3'b000, 0);
        send32(32'h3F800000, 32'h40400000, 32'h40400000, 3'b000, 0);
        send32(32'h3F800000, 32'h40800000, 32'h40800000, 3'b000, 0);
        send32(32'h3F800000, 32'h40A00000, 32'h40A00000, 3'b000, 0);
        m32.in_valid = 0;
      end
      begin
        int g = 0;
        @(negedge clk);
        while (!m32.out_valid && g < 20) begin
          @(negedge clk); g++;
        end
        m32.out_ready = 1'b0;
        #1 chk("bp_in_ready", 64'(m32.in_ready), 64'd0);
        held = m32.data_prod;
        for (int i = 0; i < 4; i++) begin
          if (i > 0) @(negedge clk);
          #1 chk("bp_hold", {31'h0, m32.out_valid, m32.data_prod},
                 {31'h0, 1'b1, held});
        end
        @(negedge clk);
        m32.out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    chk("bp_all_out", 64'(q32.size()), 64'd0);

    // Reset with three results in flight
    send32(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 0);
    send32(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 0);
    send32(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 0);
    m32.in_valid = 0;
    rst_n = 1'b0;
    q32.delete();
    #1 chk("rst_mid", {31'h0, m32.out_valid, m32.data_prod}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("post_rst_idle", 64'(m32.out_valid), 64'd0);
    end
    send32(32'hC0400000, 32'h40000000, 32'hC0C00000, 3'b000, 1);
    m32.in_valid = 0;

    // Half precision: 1.5 * 2.0 = 3.0
    send16(16'h3E00, 16'h4000, 16'h4200, 3'b000);

    begin
      int g = 0;
      while ((q32.size() != 0 || q16.size() != 0) && g < 50) begin
        @(negedge clk); g++;
      end
      chk("drain", 64'(q32.size() + q16.size()), 64'd0);
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
